// File: rtl/prmcu_uart_pkg.sv
// Shared UART subsystem types and default sizing.
package prmcu_uart_pkg;

  localparam int unsigned UART_DATA_W   = 9;
  localparam int unsigned RX_FIFO_DEPTH = 16;
  localparam int unsigned RX_FIFO_AFULL = 12;

  typedef logic [UART_DATA_W-1:0] uart_word_t;

endpackage

// File: rtl/prmcu_uart_rx_fifo_if.sv
// Receiver-to-FIFO and FIFO-to-consumer valid/ready handshake bundle.
interface prmcu_uart_rx_fifo_if
  import prmcu_uart_pkg::*;
#(
  parameter int unsigned DATA_W = UART_DATA_W
);

  logic [DATA_W-1:0] in_dat_i;
  logic              in_vld_i;
  logic              in_rdy_o;
  logic [DATA_W-1:0] out_dat_o;
  logic              out_vld_o;
  logic              out_rdy_i;

  // Producer/consumer side: drives words in, accepts words out.
  modport master (
    output in_dat_i, in_vld_i, out_rdy_i,
    input  in_rdy_o, out_dat_o, out_vld_o
  );

  // FIFO side.
  modport slave (
    input  in_dat_i, in_vld_i, out_rdy_i,
    output in_rdy_o, out_dat_o, out_vld_o
  );

endinterface

// File: rtl/prmcu_uart_rx_fifo_mem.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port, no reset.
module prmcu_uart_fifo_mem
  import prmcu_uart_pkg::*;
#(
  parameter  int unsigned DATA_W = UART_DATA_W,
  parameter  int unsigned DEPTH  = RX_FIFO_DEPTH,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prmcu_uart_rx_fifo.sv
// UART receive elastic buffer: first-word-fall-through FIFO with level, flags and sticky stall.
module prmcu_uart_rx_fifo
  import prmcu_uart_pkg::*;
#(
  parameter int unsigned DATA_W   = UART_DATA_W,
  parameter int unsigned DEPTH    = RX_FIFO_DEPTH,
  parameter int unsigned AFULL_TH = RX_FIFO_AFULL,
  localparam int unsigned AW      = $clog2(DEPTH),
  localparam int unsigned PW      = AW + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic                 flush_i,
  input  logic                 stall_clr_i,
  prmcu_uart_rx_fifo_if.slave  bus,
  output logic [PW-1:0]        level_o,
  output logic                 empty_o,
  output logic                 full_o,
  output logic                 afull_o,
  output logic                 stall_o
);

  logic [PW-1:0]     wptr_q;
  logic [PW-1:0]     rptr_q;
  logic [PW-1:0]     level_q;
  logic              stall_q;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] rd_data;

  // Extra wrap bit distinguishes full from empty when the indices coincide.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

  assign bus.in_rdy_o  = en_i & ~full & ~flush_i;
  assign bus.out_vld_o = en_i & ~empty;

  assign push = bus.in_vld_i & bus.in_rdy_o;
  assign pop  = bus.out_vld_o & bus.out_rdy_i & ~flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      if (push && !pop)      level_q <= level_q + PW'(1);
      else if (pop && !push) level_q <= level_q - PW'(1);
    end
  end

  // Sticky back-pressure flag; a new blocked attempt outranks a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     stall_q <= 1'b0;
    else if (en_i && bus.in_vld_i && !bus.in_rdy_o) stall_q <= 1'b1;
    else if (stall_clr_i)                           stall_q <= 1'b0;
  end

  prmcu_uart_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wptr_q[AW-1:0]),
    .wdata (bus.in_dat_i),
    .raddr (rptr_q[AW-1:0]),
    .rdata (rd_data)
  );

  // Storage is not reset, so the head is masked while nothing is stored.
  assign bus.out_dat_o = empty ? '0 : rd_data;

  assign level_o = level_q;
  assign empty_o = empty;
  assign full_o  = full;
  assign afull_o = (level_q >= PW'(AFULL_TH));
  assign stall_o = stall_q;

endmodule

// File: tb/tb_prmcu_uart_rx_fifo.sv
// Directed plus randomized bench for prmcu_uart_rx_fifo against a queue-based reference model.
module tb_prmcu_uart_rx_fifo;
  import prmcu_uart_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AFULL = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       flush = 1'b0;
  logic       clr = 1'b0;
  logic [4:0] level;
  logic       empty, full, afull, stall;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  uart_word_t model_q[$];
  logic       model_stall = 1'b0;
  logic [8:0] seq_dat = 9'h000;

  prmcu_uart_rx_fifo_if #(.DATA_W(UART_DATA_W)) bus ();

  prmcu_uart_rx_fifo #(
    .DATA_W   (UART_DATA_W),
    .DEPTH    (DEPTH),
    .AFULL_TH (AFULL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (en),
    .flush_i     (flush),
    .stall_clr_i (clr),
    .bus         (bus),
    .level_o     (level),
    .empty_o     (empty),
    .full_o      (full),
    .afull_o     (afull),
    .stall_o     (stall)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check, then advance the model.
  task automatic step(input logic e, input logic fl, input logic cl,
                      input logic vld, input logic [8:0] d, input logic ordy);
    int unsigned sz;
    logic exp_rdy, exp_vld;
    @(negedge clk);
    en = e; flush = fl; clr = cl;
    bus.in_vld_i = vld; bus.in_dat_i = d; bus.out_rdy_i = ordy;
    #1;
    sz      = model_q.size();
    exp_rdy = e && (sz < DEPTH) && !fl;
    exp_vld = e && (sz > 0);
    check_eq("level", 32'(level), sz);
    check_eq("empty", 32'(empty), 32'(sz == 0));
    check_eq("full", 32'(full), 32'(sz == DEPTH));
    check_eq("afull", 32'(afull), 32'(sz >= AFULL));
    check_eq("in_rdy", 32'(bus.in_rdy_o), 32'(exp_rdy));
    check_eq("out_vld", 32'(bus.out_vld_o), 32'(exp_vld));
    check_eq("stall", 32'(stall), 32'(model_stall));
    if (sz > 0) check_eq("out_dat", 32'(bus.out_dat_o), 32'(model_q[0]));
    if (fl) begin
      model_q.delete();
    end else begin
      if (exp_vld && ordy) void'(model_q.pop_front());
      if (exp_rdy && vld)  model_q.push_back(d);
    end
    if (e && vld && !exp_rdy) model_stall = 1'b1;
    else if (cl)              model_stall = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0);
  endtask

  task automatic push_n(input int unsigned n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, seq_dat, 1'b0);
      seq_dat = seq_dat + 9'd1;
    end
  endtask

  task automatic pop_n(input int unsigned n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 1'b1);
  endtask

  // Asynchronous reset asserted between edges; outputs must react without a clock edge.
  task automatic async_reset();
    @(negedge clk);
    bus.in_vld_i = 1'b0; bus.out_rdy_i = 1'b0; flush = 1'b0; clr = 1'b0; en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    model_q.delete();
    model_stall = 1'b0;
    check_eq("rst_level", 32'(level), 0);
    check_eq("rst_empty", 32'(empty), 1);
    check_eq("rst_full", 32'(full), 0);
    check_eq("rst_afull", 32'(afull), 0);
    check_eq("rst_out_vld", 32'(bus.out_vld_o), 0);
    check_eq("rst_out_dat", 32'(bus.out_dat_o), 0);
    check_eq("rst_stall", 32'(stall), 0);
    check_eq("rst_in_rdy", 32'(bus.in_rdy_o), 32'(en));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.in_vld_i = 1'b0; bus.in_dat_i = '0; bus.out_rdy_i = 1'b0;
    #1;
    check_eq("por_empty", 32'(empty), 1);
    check_eq("por_in_rdy", 32'(bus.in_rdy_o), 1);
    check_eq("por_out_dat", 32'(bus.out_dat_o), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single word round trip.
    step(1'b1, 1'b0, 1'b0, 1'b1, 9'h0A5, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 1'b1);
    idle(1);

    // Fill, blocked 17th word sets stall, drain in order.
    seq_dat = 9'h100;
    push_n(16);
    step(1'b1, 1'b0, 1'b0, 1'b1, 9'h1FF, 1'b0);
    idle(1);
    pop_n(16);

    // Full with push and pop together, then sustained streaming across wrap.
    push_n(16);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, seq_dat, 1'b1);
      seq_dat = seq_dat + 9'd1;
    end
    pop_n(16);

    // Flush at level 5 with traffic offered on both sides; stall already set stays set.
    push_n(5);
    step(1'b1, 1'b1, 1'b0, 1'b1, 9'h155, 1'b1);
    idle(1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 9'h000, 1'b0);
    idle(1);

    // Disabled with the receiver still offering words.
    push_n(3);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 9'h0EE, 1'b1);
    pop_n(3);
    idle(1);

    // Asynchronous reset at level 7, then normal traffic again.
    push_n(7);
    async_reset();
    step(1'b1, 1'b0, 1'b0, 1'b1, 9'h03C, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 9'h0C3, 1'b1);
    pop_n(2);
    idle(1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic e, fl, cl, vld, ordy;
      logic [8:0] d;
      e    = ($urandom_range(0, 9) != 0);
      fl   = ($urandom_range(0, 39) == 0);
      cl   = ($urandom_range(0, 19) == 0);
      vld  = ($urandom_range(0, 9) < ((i / 100) % 2 == 0 ? 8 : 4));
      ordy = ($urandom_range(0, 9) < ((i / 100) % 2 == 0 ? 3 : 7));
      d    = 9'($urandom);
      step(e, fl, cl, vld, d, ordy);
    end
    pop_n(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
